// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: generates the mic clock, captures one or two
// interleaved PDM channels and decimates each by ones-counting into signed samples.
module pdm_mic_frontend #(
  parameter int unsigned CLK_DIV  = 32,
  parameter int unsigned DEC_LOG2 = 8,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned NUM_CH   = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic                    mic_data_in,
  output logic                    mic_clk_out,
  output logic                    pdm_tick_out,
  output logic [NUM_CH*OUT_W-1:0] sample_out,
  output logic                    sample_valid_out,
  output logic                    clip_out
);

  localparam int unsigned DIV_W      = $clog2(CLK_DIV);
  localparam int unsigned TALLY_W    = DEC_LOG2 + 1;
  localparam int unsigned CEN_W      = DEC_LOG2 + 2;
  localparam int unsigned RES_W      = OUT_W + 1;
  localparam int unsigned SHIFT      = DEC_LOG2 - OUT_W;
  localparam int unsigned HALF_RATIO = 2 ** (DEC_LOG2 - 1);
  localparam int unsigned MAX_POS    = 2 ** (OUT_W - 1) - 1;

  logic [DIV_W-1:0]        r_div_cnt;
  logic                    r_mic_clk;
  logic [TALLY_W-1:0]      r_tally0;
  logic [DEC_LOG2-1:0]     r_frame_cnt;
  logic [NUM_CH*OUT_W-1:0] r_sample;
  logic                    r_valid;
  logic                    r_clip;

  logic                    w_cap0;
  logic                    w_last0;
  logic [TALLY_W-1:0]      w_sum0;

  // Centre the ones count, scale to OUT_W and saturate; MSB of result is the clip flag.
  function automatic logic [RES_W-1:0] f_quant(input logic [TALLY_W-1:0] tally);
    logic signed [CEN_W-1:0] v_cen;
    logic signed [CEN_W-1:0] v_shf;
    v_cen = $signed({1'b0, tally}) - $signed(CEN_W'(HALF_RATIO));
    v_shf = v_cen >>> SHIFT;
    if (v_shf > $signed(CEN_W'(MAX_POS))) begin
      f_quant = {1'b1, OUT_W'(MAX_POS)};
    end else begin
      f_quant = {1'b0, v_shf[OUT_W-1:0]};
    end
  endfunction

  assign w_cap0  = enable_in && (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_last0 = w_cap0 && (r_frame_cnt == '1);
  assign w_sum0  = r_tally0 + TALLY_W'(mic_data_in);

  // Clock divider, mic clock and channel-0 accumulation
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_div_cnt   <= '0;
      r_mic_clk   <= 1'b0;
      r_tally0    <= '0;
      r_frame_cnt <= '0;
    end else if (!enable_in) begin
      r_div_cnt   <= '0;
      r_mic_clk   <= 1'b0;
      r_tally0    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : r_div_cnt + DIV_W'(1);
      r_mic_clk <= (r_div_cnt < DIV_W'(CLK_DIV / 2));
      if (w_cap0) begin
        r_tally0    <= w_last0 ? '0 : w_sum0;
        r_frame_cnt <= r_frame_cnt + DEC_LOG2'(1);
      end
    end
  end

  if (NUM_CH == 2) begin : gen_two_ch
    logic               r_started;
    logic               r_pending;
    logic [TALLY_W-1:0] r_tally1;
    logic [TALLY_W-1:0] r_done0;
    logic               w_cap1;
    logic               w_fin;
    logic [TALLY_W-1:0] w_sum1;
    logic [RES_W-1:0]   w_res0;
    logic [RES_W-1:0]   w_res1;

    // Channel 1 only counts captures that follow a channel-0 capture, so both
    // channels see exactly one full frame of bits.
    assign w_cap1 = enable_in && r_started && (r_div_cnt == DIV_W'(CLK_DIV / 2 - 1));
    assign w_fin  = w_cap1 && r_pending;
    assign w_sum1 = r_tally1 + TALLY_W'(mic_data_in);
    assign w_res0 = f_quant(r_done0);
    assign w_res1 = f_quant(w_sum1);

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_started <= 1'b0;
        r_pending <= 1'b0;
        r_tally1  <= '0;
        r_done0   <= '0;
        r_sample  <= '0;
        r_valid   <= 1'b0;
        r_clip    <= 1'b0;
      end else if (!enable_in) begin
        r_started <= 1'b0;
        r_pending <= 1'b0;
        r_tally1  <= '0;
        r_done0   <= '0;
        r_valid   <= 1'b0;
        r_clip    <= 1'b0;
      end else begin
        r_valid <= w_fin;
        r_clip  <= w_fin && (w_res0[OUT_W] || w_res1[OUT_W]);
        if (w_cap0) r_started <= 1'b1;
        if (w_last0) begin
          r_pending <= 1'b1;
          r_done0   <= w_sum0;
        end else if (w_fin) begin
          r_pending <= 1'b0;
        end
        if (w_cap1) r_tally1 <= w_fin ? '0 : w_sum1;
        if (w_fin) r_sample <= {w_res1[OUT_W-1:0], w_res0[OUT_W-1:0]};
      end
    end
  end else begin : gen_one_ch
    logic [RES_W-1:0] w_res0;

    assign w_res0 = f_quant(w_sum0);

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_sample <= '0;
        r_valid  <= 1'b0;
        r_clip   <= 1'b0;
      end else begin
        r_valid <= w_last0;
        r_clip  <= w_last0 && w_res0[OUT_W];
        if (w_last0) r_sample <= w_res0[OUT_W-1:0];
      end
    end
  end

  assign mic_clk_out      = r_mic_clk;
  assign pdm_tick_out     = w_cap0;
  assign sample_out       = r_sample;
  assign sample_valid_out = r_valid;
  assign clip_out         = r_clip;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Bench for pdm_mic_frontend: table of per-frame bit patterns on a default instance,
// plus two-channel and OUT_W=4 instances, abort and mid-frame reset sequences.
module tb_pdm_mic_frontend;

  localparam int FRAME = 8192;

  typedef struct {
    bit         alt;
    int         n_ones;
    logic [7:0] smp;
    logic       clp;
  } vec_t;

  typedef struct {
    logic [15:0] smp;
    logic        clp;
    longint      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en0, en1, en2;
  logic d0, d1, d2;
  logic mc0, tk0, sv0, cl0;
  logic mc1, tk1, sv1, cl1;
  logic mc2, tk2, sv2, cl2;
  logic [7:0]  s0;
  logic [15:0] s1;
  logic [3:0]  s2;

  vec_t   vt[8];
  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint base = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  assign d1 = mc1;

  pdm_mic_frontend u0 (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en0), .mic_data_in(d0),
    .mic_clk_out(mc0), .pdm_tick_out(tk0), .sample_out(s0),
    .sample_valid_out(sv0), .clip_out(cl0));

  pdm_mic_frontend #(.NUM_CH(2)) u1 (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en1), .mic_data_in(d1),
    .mic_clk_out(mc1), .pdm_tick_out(tk1), .sample_out(s1),
    .sample_valid_out(sv1), .clip_out(cl1));

  pdm_mic_frontend #(.OUT_W(4)) u2 (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en2), .mic_data_in(d2),
    .mic_clk_out(mc2), .pdm_tick_out(tk2), .sample_out(s2),
    .sample_valid_out(sv2), .clip_out(cl2));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected frame, value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sv0 !== 1'b0) begin
      if (q0.size() == 0) check("u0_unexpected_strobe", 64'(sv0), 64'(0));
      else begin
        e = q0.pop_front();
        check("u0_sample", 64'(s0), 64'(e.smp));
        check("u0_clip", 64'(cl0), 64'(e.clp));
        check("u0_strobe_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (cl0 !== 1'b0) check("u0_stray_clip", 64'(cl0), 64'(0));
    if (sv1 !== 1'b0) begin
      if (q1.size() == 0) check("u1_unexpected_strobe", 64'(sv1), 64'(0));
      else begin
        e = q1.pop_front();
        check("u1_sample", 64'(s1), 64'(e.smp));
        check("u1_clip", 64'(cl1), 64'(e.clp));
        check("u1_strobe_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (sv2 !== 1'b0) begin
      if (q2.size() == 0) check("u2_unexpected_strobe", 64'(sv2), 64'(0));
      else begin
        e = q2.pop_front();
        check("u2_sample", 64'(s2), 64'(e.smp));
        check("u2_clip", 64'(cl2), 64'(e.clp));
        check("u2_strobe_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drives n frames from the table, starting right after a release at cycle 'base'.
  task automatic run_frames(input int first, input int n);
    for (int r = 1; r <= n * FRAME; r++) begin
      @(negedge clk);
      if (first == 0 && r <= 64) begin
        check("mic_clk_phase", 64'(mc0), 64'((r % 32 >= 1) && (r % 32 <= 16)));
        check("pdm_tick_phase", 64'(tk0), 64'(r % 32 == 31));
      end
      if (r % 32 == 31) begin
        int k, f, idx;
        k   = r / 32;
        f   = k / 256;
        idx = k % 256;
        d0  = vt[first+f].alt ? (idx % 2 == 0) : (idx < vt[first+f].n_ones);
        if (idx == 255) q0.push_back('{16'(vt[first+f].smp), vt[first+f].clp, cyc + 1});
        if (en2) begin
          d2 = (idx < 192);
          if (idx == 255) begin
            q2.push_back('{16'h0004, 1'b0, cyc + 1});
            q1.push_back('{16'h7F80, 1'b1, cyc + 17});
          end
        end
      end
      if (r == 3 * FRAME + 20 && en1) begin
        en1 = 1'b0;
        en2 = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    d0 = 1'b0; d2 = 1'b0;
    vt[0] = '{1'b0, 256, 8'h7F, 1'b1};
    vt[1] = '{1'b0,   0, 8'h80, 1'b0};
    vt[2] = '{1'b1,   0, 8'h00, 1'b0};
    vt[3] = '{1'b0, 192, 8'h40, 1'b0};
    vt[4] = '{1'b0, 255, 8'h7F, 1'b0};
    vt[5] = '{1'b0,   1, 8'h81, 1'b0};
    vt[6] = '{1'b0,   0, 8'h80, 1'b0};
    vt[7] = '{1'b0, 256, 8'h7F, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_mic_clk", 64'(mc0), 64'(0));
    check("rst_tick", 64'(tk0 | tk1 | tk2), 64'(0));
    check("rst_sample0", 64'(s0), 64'(0));
    check("rst_sample1", 64'(s1), 64'(0));
    check("rst_sample2", 64'(s2), 64'(0));
    check("rst_valid", 64'(sv0 | sv1 | sv2), 64'(0));
    check("rst_clip", 64'(cl0 | cl1 | cl2), 64'(0));
    check("rst_mic_clk_12", 64'(mc1 | mc2), 64'(0));

    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    run_frames(0, 6);

    // Abort: enable drops at capture 100 of a frame of ones, fresh frame of zeros follows.
    for (int j = 1; j <= 100 * 32 + 31; j++) begin
      @(negedge clk);
      if (j % 32 == 31) begin
        if (j / 32 < 100) d0 = 1'b1;
        else en0 = 1'b0;
      end
    end
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 50) begin
        check("dis_mic_clk", 64'(mc0), 64'(0));
        check("dis_tick", 64'(tk0), 64'(0));
        check("dis_sample_hold", 64'(s0), 64'(8'h81));
        check("dis_u1_sample_hold", 64'(s1), 64'(16'h7F80));
        check("dis_u2_sample_hold", 64'(s2), 64'(4'h4));
      end
    end
    en0 = 1'b1;
    base = cyc;
    run_frames(6, 1);

    // Mid-frame reset: aborted frame gives no strobe, outputs clear immediately.
    d0 = 1'b1;
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sample0", 64'(s0), 64'(0));
    check("midrst_mic_clk", 64'(mc0), 64'(0));
    check("midrst_tick", 64'(tk0), 64'(0));
    check("midrst_sample1", 64'(s1), 64'(0));
    check("midrst_sample2", 64'(s2), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    run_frames(7, 1);

    repeat (40) @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    check("q2_drained", 64'(q2.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_mic_frontend.md
PDM_MIC_FRONTEND -- requirements
Module: pdm_mic_frontend

Interface
REQ-001 Parameter CLK_DIV, default 32: system clocks per mic clock period; even and at least 4.
REQ-002 Parameter DEC_LOG2, default 8: decimation ratio is DEC_RATIO = 2**DEC_LOG2 PDM bits per output sample, per channel.
REQ-003 Parameter OUT_W, default 8: output sample width per channel; 2 <= OUT_W <= DEC_LOG2.
REQ-004 Parameter NUM_CH, default 1: channel count, 1 or 2.
REQ-005 clk_in  input  1  sole clock; all state on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-low.
REQ-007 enable_in  input  1  run control; low stops the mic clock and clears the decimators.
REQ-008 mic_data_in  input  1  PDM data from the microphone(s).
REQ-009 mic_clk_out  output  1  registered microphone clock.
REQ-010 pdm_tick_out  output  1  one-cycle pulse on each channel-0 bit capture.
REQ-011 sample_out  output  NUM_CH*OUT_W  signed samples, channel 0 in [OUT_W-1:0], channel 1 above it.
REQ-012 sample_valid_out  output  1  one-cycle strobe; sample_out is valid on that cycle.
REQ-013 clip_out  output  1  one-cycle strobe with sample_valid_out when any channel saturated.

Function
REQ-014 The divider counter div_cnt SHALL count 0..CLK_DIV-1 and wrap to 0 while enable_in is high.
REQ-015 mic_clk_out SHALL register (div_cnt < CLK_DIV/2), giving a 50% duty cycle with period CLK_DIV.
REQ-016 Channel 0 SHALL capture mic_data_in in the cycle where div_cnt == CLK_DIV-1 (end of the low phase); pdm_tick_out pulses in that same cycle.
REQ-017 When NUM_CH=2, channel 1 SHALL capture mic_data_in in the cycle where div_cnt == CLK_DIV/2-1 (end of the high phase).
REQ-018 Each channel SHALL own a tally of DEC_LOG2+1 bits that adds each captured bit (range 0..DEC_RATIO).
REQ-019 A frame counter SHALL count channel-0 captures 0..DEC_RATIO-1; a frame is exactly DEC_RATIO captures per channel, with none dropped or duplicated.
REQ-020 A frame SHALL complete on the last channel-0 capture when NUM_CH=1, and on the following channel-1 capture when NUM_CH=2.
REQ-021 On frame completion, per channel: centred = tally - DEC_RATIO/2 (signed, -DEC_RATIO/2..+DEC_RATIO/2), then arithmetic right shift by DEC_LOG2-OUT_W.
REQ-022 The shifted value SHALL saturate to the signed OUT_W range; +2**(OUT_W-1) becomes 2**(OUT_W-1)-1, and this sets clip for that channel.
REQ-023 sample_out, sample_valid_out and clip_out SHALL update in the cycle after the completing capture (latency 1); sample_out holds until the next frame.
REQ-024 The completing capture's bit SHALL be included in the finished frame; the tallies restart at 0 for the next frame with no gap.
REQ-025 When enable_in is low: div_cnt, tallies and frame counter are held at 0; mic_clk_out is 0; no ticks or strobes occur; sample_out retains its last value.
REQ-026 Deasserting enable_in mid-frame SHALL discard the partial frame; after re-enable, the first frame starts fresh at div_cnt=0.

Reset
REQ-027 While rst_in is low, all state SHALL clear asynchronously: div_cnt, tallies, frame counter and sample_out=0; mic_clk_out, pdm_tick_out, sample_valid_out and clip_out=0.
REQ-028 After rst_in rises with enable_in high, div_cnt SHALL start at 0 on the first clock; a reset mid-frame produces no strobe for the aborted frame.

Verification
REQ-029 Defaults, mic_data_in=1, cycle 0 = first post-reset edge -> first sample_valid_out at cycle 8192, sample_out=0x7F, clip_out=1; then a strobe every 8192 cycles.
REQ-030 Defaults, mic_data_in=0 -> sample_out=0x80 (-128), clip_out=0.
REQ-031 Defaults, mic_data_in toggling on each pdm_tick_out -> sample_out=0x00; mic_clk_out period 32 with 16 cycles high.
REQ-032 NUM_CH=2, mic_data_in = mic_clk_out -> channel 1 = 0x7F with clip, channel 0 = 0x80; sample_out=16'h7F80.
REQ-033 DEC_LOG2=8, OUT_W=4, 192 ones per frame -> centred=+64, shifted by 4 = 4, sample_out=4'h4, no clip.
REQ-034 enable_in low for 100 cycles at capture 100 of a frame, then high -> no strobe for the aborted frame; next strobe exactly 8192 cycles after re-enable, with the correct value for the fresh frame.
